// File: rtl/rc4_pkg.sv
// Shared RC4 definitions: S-box size, default key geometry and the KSA state encoding.
// Each state code carries its bus-control bits so outputs decode straight off the state register.
package rc4_pkg;

  localparam int S_SIZE     = 256;
  localparam int KEY_LENGTH = 3;
  localparam int KEY_WIDTH  = 8 * KEY_LENGTH;

  // Low nibble of each state code: {finish, write enable, address=i, address=j}.
  localparam int FINISH_BIT = 3;
  localparam int WE_BIT     = 2;
  localparam int ADDR_I_BIT = 1;
  localparam int ADDR_J_BIT = 0;

  typedef enum logic [7:0] {
    KSA_IDLE          = 8'h00,
    KSA_READ_SI       = 8'h12,
    KSA_REGISTER_SI   = 8'h22,
    KSA_UPDATE_J      = 8'h30,
    KSA_READ_SJ       = 8'h41,
    KSA_REGISTER_SJ   = 8'h51,
    KSA_WRITE_SI_TO_J = 8'h65,
    KSA_WRITE_SJ_TO_I = 8'h76,
    KSA_ADVANCE_I     = 8'h80,
    KSA_FINISH        = 8'h98
  } ksa_state_t;

endpackage

// File: rtl/rc4_key_byte_select.sv
// Selects key byte kidx from the latched key; byte 0 sits in the most significant bits.
module rc4_key_byte_select #(
  parameter int KEY_LENGTH = 3,
  parameter int KEY_WIDTH  = 8 * KEY_LENGTH,
  parameter int KIDX_W     = 2
) (
  input  logic [KEY_WIDTH-1:0] key,
  input  logic [KIDX_W-1:0]    kidx,
  output logic [7:0]           key_byte
);

  // NOTE: the default assignment ahead of the loop keeps this purely combinational (no latch).
  always_comb begin
    key_byte = '0;
    for (int k = 0; k < KEY_LENGTH; k++) begin
      if (kidx == KIDX_W'(k)) key_byte = key[KEY_WIDTH-1-8*k -: 8];
    end
  end

endmodule

// File: rtl/rc4_key_schedule.sv
// RC4 key-scheduling swap pass over a shared single-port 256x8 S RAM.
// Eight states per index: read S[i], update j, read S[j], write both back, advance.
module rc4_key_schedule #(
  parameter int KEY_LENGTH = rc4_pkg::KEY_LENGTH,
  parameter int KEY_WIDTH  = 8 * KEY_LENGTH
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [KEY_WIDTH-1:0] secret_key,
  input  logic [7:0]           data_from_s,
  output logic                 is_write_s,
  output logic [7:0]           address_out_s,
  output logic [7:0]           data_to_s,
  output logic                 finish
);
  import rc4_pkg::*;

  localparam int KIDX_W = (KEY_LENGTH > 1) ? $clog2(KEY_LENGTH) : 1;

  ksa_state_t           state;
  logic [7:0]           i, j, s_i, s_j, key_byte;
  logic [KIDX_W-1:0]    kidx;
  logic [KEY_WIDTH-1:0] key_q;

  rc4_key_byte_select #(
    .KEY_LENGTH(KEY_LENGTH),
    .KEY_WIDTH (KEY_WIDTH),
    .KIDX_W    (KIDX_W)
  ) u_key_byte_select (
    .key     (key_q),
    .kidx    (kidx),
    .key_byte(key_byte)
  );

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= KSA_IDLE;
      i     <= '0;
      j     <= '0;
      kidx  <= '0;
      s_i   <= '0;
      s_j   <= '0;
      key_q <= '0;
    end else begin
      case (state)
        KSA_IDLE: begin
          if (start) begin
            key_q <= secret_key;
            i     <= '0;
            j     <= '0;
            kidx  <= '0;
            state <= KSA_READ_SI;
          end
        end
        KSA_READ_SI:     state <= KSA_REGISTER_SI;
        KSA_REGISTER_SI: begin
          s_i   <= data_from_s;
          state <= KSA_UPDATE_J;
        end
        KSA_UPDATE_J: begin
          j     <= j + s_i + key_byte;
          state <= KSA_READ_SJ;
        end
        KSA_READ_SJ:     state <= KSA_REGISTER_SJ;
        KSA_REGISTER_SJ: begin
          s_j   <= data_from_s;
          state <= KSA_WRITE_SI_TO_J;
        end
        KSA_WRITE_SI_TO_J: state <= KSA_WRITE_SJ_TO_I;
        KSA_WRITE_SJ_TO_I: state <= KSA_ADVANCE_I;
        KSA_ADVANCE_I: begin
          // Key index wraps as a counter; i wraps to 0 but the pass ends here.
          i     <= i + 8'd1;
          kidx  <= (kidx == KIDX_W'(KEY_LENGTH - 1)) ? '0 : kidx + KIDX_W'(1);
          state <= (i == 8'(S_SIZE - 1)) ? KSA_FINISH : KSA_READ_SI;
        end
        KSA_FINISH: begin
          i     <= '0;
          j     <= '0;
          kidx  <= '0;
          state <= KSA_IDLE;
        end
        default: state <= KSA_IDLE;
      endcase
    end
  end

  // Bus outputs depend only on registered state, never on inputs.
  always_comb begin
    is_write_s    = state[WE_BIT];
    finish        = state[FINISH_BIT];
    address_out_s = '0;
    data_to_s     = '0;
    if (state[ADDR_I_BIT])      address_out_s = i;
    else if (state[ADDR_J_BIT]) address_out_s = j;
    if (state[WE_BIT])          data_to_s = state[ADDR_J_BIT] ? s_i : s_j;
  end

endmodule

// File: doc/rc4_key_schedule.md
Name: rc4_key_schedule

Overview:
RC4 key-scheduling (KSA swap) stage that runs directly upstream of the per-byte decryption stage. It runs after S has been initialised to identity (S[n]=n). For i = 0..255 it computes j = j + S[i] + key[i mod KEY_LENGTH] and swaps S[i] with S[j]. It accesses the shared 256x8 single-port S RAM over the same read/write bus the decryption stage uses, and signals completion with a one-cycle finish pulse.

Parameters:
KEY_LENGTH, 3, number of key bytes.
KEY_WIDTH, 8*KEY_LENGTH, width of secret_key in bits.

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous active-low reset
start  input  1  begin schedule; sampled only in idle
secret_key  input  KEY_WIDTH  key; byte 0 = secret_key[KEY_WIDTH-1 -: 8] (MSB first)
data_from_s  input  8  S RAM read data
is_write_s  output  1  S RAM write enable
address_out_s  output  8  S RAM address
data_to_s  output  8  S RAM write data
finish  output  1  one-cycle done pulse

Behaviour:
- Reset is rst_n, asynchronous, active-low; clock is clk. Reset forces idle; i, j, key index, s_i, s_j and latched key are cleared to 0.
- Reset values of outputs: is_write_s=0, address_out_s=0, data_to_s=0, finish=0.
- All outputs are decoded from the state register only (no input-to-output combinational path).
- S RAM timing: address is presented in a read state. data_from_s is valid and captured in the following register state, with the address held.
- In idle, start=1 latches secret_key and clears i, j and key index. The next state is read_si. start is ignored in all other states.
- Per-iteration state sequence, 8 cycles:
  - read_si: addr=i.
  - register_si: addr=i; s_i<=data_from_s.
  - update_j: j<=j+s_i+key_byte[kidx], mod 256.
  - read_sj: addr=j.
  - register_sj: addr=j; s_j<=data_from_s.
  - write_si_to_j: addr=j, data=s_i, we=1.
  - write_sj_to_i: addr=i, data=s_j, we=1.
  - advance_i: i<=i+1; kidx<=(kidx==KEY_LENGTH-1)?0:kidx+1; next state is finish_state if i==255, else read_si.
- finish_state: finish=1 for one cycle and i, j, kidx are cleared. The next state is idle.
- Latency: finish is high exactly 2049 cycles after the edge that sampled start (1+256*8).
- Outside read, register and write states: address_out_s=0. data_to_s=0 whenever is_write_s=0.
- The key index is a wrapping counter; no divider is used.
- i==j: both writes go to the same address with the same value, so S is unchanged. This is correct and needs no special case.
- i wraps 255->0 at the end, but the state goes to finish_state, so there is no 257th iteration.
- secret_key changes after start has no effect until the next start.
- Reset mid-operation: returns to idle immediately with no finish pulse. S contents are then undefined; the system controller must re-initialise S before a new start.

Decomposition:
- Shared package rc4_pkg: S_SIZE=256, KEY_LENGTH=3, KEY_WIDTH, and the ksa_state_t enum. The enum uses explicit encodings with output bits embedded, the same style as the decryption stage.
- Optional sub-module rc4_key_byte_select: combinational mux selecting key byte kidx from the latched key. All other logic stays in one module.

Test Plan:
- Key 24'h000000, S identity, pulse start → iteration 0 writes (addr0,data0) twice. Iteration 1 writes (addr1,data1) twice. Iteration 2 writes (addr3,data2), then (addr2,data3).
- Key 24'h000249, S identity → finish pulses exactly 2049 cycles after start, for exactly one cycle. Final 256-byte S matches the software RC4 KSA model.
- Key 24'h010203 → update_j uses key bytes 0x01, 0x02, 0x03, 0x01 for i=0,1,2,3 (wrap checked at i=3 and i=255, where kidx=0).
- start re-asserted at cycles 10 and 500 mid-run → ignored. Total latency is still 2049 and the key latched at the first start is used.
- rst_n low during iteration i=100 → outputs 0 asynchronously, state idle, no finish. After re-init of S and a new start, the result matches the model.
- Bus check over a full run → is_write_s is high for exactly 512 cycles, and data_to_s/address_out_s are 0 in idle, update_j and advance_i.
